mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: address width of all address ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of all data ports.
REQ-003 SHALL have port: clk  input  1  single clock, rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: IF_req_ip  input  1  fetch read request.
REQ-006 SHALL have port: IF_addr_ip  input  ADDR_WIDTH  fetch address.
REQ-007 SHALL have port: IF_gnt_op  output  1  fetch request accepted.
REQ-008 SHALL have port: IF_rvalid_op  output  1  fetch response valid.
REQ-009 SHALL have port: LSU_req_ip  input  1  load/store request.
REQ-010 SHALL have port: LSU_we_ip  input  1  1 = store, 0 = load.
REQ-011 SHALL have port: LSU_addr_ip  input  ADDR_WIDTH  load/store address.
REQ-012 SHALL have port: LSU_wdata_ip  input  DATA_WIDTH  store data.
REQ-013 SHALL have port: LSU_gnt_op  output  1  LSU request accepted.
REQ-014 SHALL have port: LSU_rvalid_op  output  1  LSU response valid (loads and stores).
REQ-015 SHALL have port: rdata_op  output  DATA_WIDTH  shared read data, qualified by either rvalid.
REQ-016 SHALL have ports: mem_req_op, mem_we_op  output  1; mem_addr_op  output  ADDR_WIDTH; mem_wdata_op  output  DATA_WIDTH  single memory port.
REQ-017 SHALL have ports: mem_gnt_ip, mem_rvalid_ip  input  1; mem_rdata_ip  input  DATA_WIDTH  memory handshake and response.
REQ-018 SHALL have port: stall_op  output  1  pipeline stall while an LSU access is incomplete.

Function
REQ-019 SHALL implement FSM states ARB_IDLE, ARB_WAIT_IF, ARB_WAIT_LSU, with at most one outstanding memory transaction.
REQ-020 In ARB_IDLE, SHALL drive the selected requester onto mem_* combinationally in the same cycle: zero-cycle request latency.
REQ-021 Selection SHALL default to fixed priority: LSU over IF.
REQ-022 Once mem_req_op is asserted without mem_gnt_ip, the selected owner SHALL be locked in a register until grant, even if the other requester asserts.
REQ-023 X_gnt_op SHALL equal mem_gnt_ip AND (owner == X); on grant, the FSM SHALL go to ARB_WAIT_X.
REQ-024 In ARB_WAIT_X, the FSM SHALL hold mem_req_op at 0, set X_rvalid_op = mem_rvalid_ip, and return to ARB_IDLE on mem_rvalid_ip.
REQ-025 New arbitration SHALL occur only in ARB_IDLE, giving a minimum of 2 cycles per transaction.
REQ-026 rdata_op SHALL be mem_rdata_ip passed through; mem_we_op SHALL be 0 whenever IF owns the port.
REQ-027 stall_op SHALL be 1 when (LSU_req_ip AND NOT LSU_gnt_op) OR (state == ARB_WAIT_LSU AND NOT mem_rvalid_ip), else 0.
REQ-028 mem_rvalid_ip in ARB_IDLE SHALL be ignored: no rvalid output asserted and no state change.

Reset
REQ-029 Asserting reset (low) SHALL force ARB_IDLE, clear the owner lock and round-robin flag, and set all outputs to 0 except data passthroughs.
REQ-030 Reset mid-transaction SHALL abandon the transaction; any late mem_rvalid_ip SHALL be handled per REQ-028.

Configuration
REQ-031 With MEM_ARB_ROUND_ROBIN_EN defined, simultaneous IF and LSU requests in ARB_IDLE SHALL grant the requester not served last, tracked by a 1-bit last-owner flag updated on grant; without it, fixed priority per REQ-021 SHALL apply.

Structure
REQ-032 The arb_state_t enum and owner_t (OWNER_IF, OWNER_LSU) SHALL be placed in CORE_PKG.
REQ-033 The block SHALL be a single module with no sub-modules.

Verification
REQ-034 The bench SHALL check: IF_req alone, addr 0x100, gnt same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF -> IF_gnt_op=1 in cycle 0, IF_rvalid_op=1 in cycle 2, stall_op=0 throughout.
REQ-035 The bench SHALL check: IF and LSU load request in the same cycle, macro off -> LSU granted first, IF granted in the first ARB_IDLE after LSU rvalid.
REQ-036 The bench SHALL check: same as REQ-035 with macro on, LSU served last -> IF granted first.
REQ-037 The bench SHALL check: IF requested with gnt held 0 for 3 cycles while LSU asserts in cycle 1 -> mem_addr_op stays the IF address until grant; stall_op=1 during those cycles.
REQ-038 The bench SHALL check: LSU store 0x55 to 0x200, then reset while in ARB_WAIT_LSU, then stray mem_rvalid_ip -> ARB_IDLE, LSU_rvalid_op stays 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the memory-port arbiter: FSM state and port-owner encodings.
package core_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_WAIT_IF  = 2'd1,
        ARB_WAIT_LSU = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_LSU = 1'b1
    } owner_t;

endpackage : core_pkg

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single memory port, one outstanding access.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate between requesters on simultaneous requests.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  IF_req_ip,
    input  logic [ADDR_WIDTH-1:0] IF_addr_ip,
    output logic                  IF_gnt_op,
    output logic                  IF_rvalid_op,

    input  logic                  LSU_req_ip,
    input  logic                  LSU_we_ip,
    input  logic [ADDR_WIDTH-1:0] LSU_addr_ip,
    input  logic [DATA_WIDTH-1:0] LSU_wdata_ip,
    output logic                  LSU_gnt_op,
    output logic                  LSU_rvalid_op,

    output logic [DATA_WIDTH-1:0] rdata_op,

    output logic                  mem_req_op,
    output logic                  mem_we_op,
    output logic [ADDR_WIDTH-1:0] mem_addr_op,
    output logic [DATA_WIDTH-1:0] mem_wdata_op,
    input  logic                  mem_gnt_ip,
    input  logic                  mem_rvalid_ip,
    input  logic [DATA_WIDTH-1:0] mem_rdata_ip,

    output logic                  stall_op
);

    arb_state_t state_q, state_d;
    logic       lock_vld_q, lock_vld_d;
    owner_t     lock_owner_q, lock_owner_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t     last_owner_q, last_owner_d;
`endif

    owner_t     sel_owner;
    logic       sel_req;
    logic       if_gnt;
    logic       lsu_gnt;

    assign rdata_op = mem_rdata_ip;

    // A request left ungranted stays with the locked owner, so the address
    // presented to memory cannot switch under an in-progress handshake.
    always_comb begin
        sel_owner = OWNER_IF;
        sel_req   = lock_vld_q || IF_req_ip || LSU_req_ip;
        if (lock_vld_q) begin
            sel_owner = lock_owner_q;
        end else if (IF_req_ip && LSU_req_ip) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            sel_owner = (last_owner_q == OWNER_LSU) ? OWNER_IF : OWNER_LSU;
`else
            sel_owner = OWNER_LSU;
`endif
        end else if (LSU_req_ip) begin
            sel_owner = OWNER_LSU;
        end
    end

    always_comb begin
        state_d       = state_q;
        lock_vld_d    = lock_vld_q;
        lock_owner_d  = lock_owner_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_owner_d  = last_owner_q;
`endif
        if_gnt        = 1'b0;
        lsu_gnt       = 1'b0;
        IF_rvalid_op  = 1'b0;
        LSU_rvalid_op = 1'b0;
        mem_req_op    = 1'b0;
        mem_we_op     = 1'b0;
        mem_addr_op   = '0;
        mem_wdata_op  = '0;

        case (state_q)
            ARB_IDLE: begin
                if (sel_req) begin
                    mem_req_op = 1'b1;
                    if (sel_owner == OWNER_LSU) begin
                        mem_we_op    = LSU_we_ip;
                        mem_addr_op  = LSU_addr_ip;
                        mem_wdata_op = LSU_wdata_ip;
                    end else begin
                        mem_addr_op  = IF_addr_ip;
                    end

                    if (mem_gnt_ip) begin
                        if_gnt     = (sel_owner == OWNER_IF);
                        lsu_gnt    = (sel_owner == OWNER_LSU);
                        lock_vld_d = 1'b0;
                        state_d    = (sel_owner == OWNER_LSU) ? ARB_WAIT_LSU : ARB_WAIT_IF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_owner_d = sel_owner;
`endif
                    end else begin
                        lock_vld_d   = 1'b1;
                        lock_owner_d = sel_owner;
                    end
                end
            end

            ARB_WAIT_IF: begin
                IF_rvalid_op = mem_rvalid_ip;
                if (mem_rvalid_ip) begin
                    state_d = ARB_IDLE;
                end
            end

            ARB_WAIT_LSU: begin
                LSU_rvalid_op = mem_rvalid_ip;
                if (mem_rvalid_ip) begin
                    state_d = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        IF_gnt_op  = if_gnt;
        LSU_gnt_op = lsu_gnt;
        stall_op   = (LSU_req_ip && !lsu_gnt) ||
                     ((state_q == ARB_WAIT_LSU) && !mem_rvalid_ip);

        // Outputs are held quiet while reset is asserted, not just after the next edge.
        if (!reset) begin
            IF_gnt_op     = 1'b0;
            LSU_gnt_op    = 1'b0;
            IF_rvalid_op  = 1'b0;
            LSU_rvalid_op = 1'b0;
            mem_req_op    = 1'b0;
            mem_we_op     = 1'b0;
            mem_addr_op   = '0;
            mem_wdata_op  = '0;
            stall_op      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            lock_vld_q   <= 1'b0;
            lock_owner_q <= OWNER_IF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner_q <= OWNER_IF;
`endif
        end else begin
            state_q      <= state_d;
            lock_vld_q   <= lock_vld_d;
            lock_owner_q <= lock_owner_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

endmodule : mem_port_arbiter
